// File: rtl/maquina_bebidas_param.sv
// Purpose: parametrised vending controller; accumulates coin credit, serves one of N_BEV drinks, returns change/refund.
// Latency: all outputs registered, 1 clk from strobe to response; serve lasts SERVE_CYCLES clocks.
// Backpressure: coin, request and cancel strobes are ignored outside IDLE/CREDIT; an overflowing coin is bounced back.
module maquina_bebidas_param #(
  parameter int N_BEV        = 2,
  parameter int CREDIT_W     = 5,
  parameter int COIN_W       = 4,
  parameter logic [N_BEV*CREDIT_W-1:0] PRICES = {5'd10, 5'd5},
  parameter int SERVE_CYCLES = 8,
  parameter int SEL_W        = (N_BEV > 1) ? $clog2(N_BEV) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hm,
  input  logic [COIN_W-1:0]   tm,
  input  logic                ha,
  input  logic [N_BEV-1:0]    hc,
  input  logic                bp,
  input  logic [SEL_W-1:0]    bb,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_BEV-1:0]    serve,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change,
  output logic [2:0]          out
);

  // Sum wide enough to hold credit + coin without wrapping, so overflow is detectable.
  localparam int SUM_W = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;
  localparam int CNT_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_CYCLES - 1);

  // Status codes driven on out.
  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_CREDIT   = 3'b001;
  localparam logic [2:0] ST_SERVING  = 3'b010;
  localparam logic [2:0] ST_CHANGE   = 3'b011;
  localparam logic [2:0] ST_NO_WATER = 3'b100;
  localparam logic [2:0] ST_NO_INGR  = 3'b101;
  localparam logic [2:0] ST_REFUND   = 3'b110;
  localparam logic [2:0] ST_NO_FUNDS = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    CREDIT,
    SERVE,
    CHANGE,
    REFUND
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  logic [N_BEV-1:0]    sel_oh;
  logic [CREDIT_W-1:0] price_sel;
  logic                sel_ok;
  logic                ing_ok;
  logic                funds_ok;
  logic [SUM_W-1:0]    coin_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] credit_plus_coin;

  // Decode the selector into a one-hot and pick its price; out-of-range selects yield an all-zero one-hot.
  always_comb begin
    sel_oh    = '0;
    price_sel = '0;
    for (int i = 0; i < N_BEV; i++) begin
      if (int'(bb) == i) begin
        sel_oh[i] = 1'b1;
        price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  assign sel_ok           = |sel_oh;
  assign ing_ok           = |(hc & sel_oh);
  assign funds_ok         = (credit >= price_sel);
  assign coin_sum         = SUM_W'(credit) + SUM_W'(tm);
  assign coin_fits        = (coin_sum[SUM_W-1:CREDIT_W] == '0);
  assign credit_plus_coin = coin_sum[CREDIT_W-1:0];

  // Controller FSM with every output registered; reset closes the valves asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      credit       <= '0;
      serve        <= '0;
      change_valid <= 1'b0;
      change       <= '0;
      out          <= ST_IDLE;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE, CREDIT: begin
          // Default: no pulse, status reflects held credit (also clears one-cycle transient codes).
          change_valid <= 1'b0;
          change       <= '0;
          serve        <= '0;
          out          <= (credit != '0) ? ST_CREDIT : ST_IDLE;
          // A cancel with nothing to return does not act, so it does not mask coins or requests.
          if (cancel && (credit != '0)) begin
            state        <= REFUND;
            change_valid <= 1'b1;
            change       <= credit;
            credit       <= '0;
            out          <= ST_REFUND;
          end else if (hm) begin
            if (coin_fits) begin
              credit <= credit_plus_coin;
              state  <= CREDIT;
              out    <= (credit_plus_coin != '0) ? ST_CREDIT : ST_IDLE;
            end else begin
              // Coin would overflow the credit register: bounce it straight back.
              change_valid <= 1'b1;
              change       <= CREDIT_W'(tm);
              out          <= ST_REFUND;
            end
          end else if (bp) begin
            if (!ha) begin
              // Water is checked first, even ahead of a bad select.
              state        <= REFUND;
              change_valid <= 1'b1;
              change       <= credit;
              credit       <= '0;
              out          <= ST_NO_WATER;
            end else if (!sel_ok || !ing_ok) begin
              state        <= REFUND;
              change_valid <= 1'b1;
              change       <= credit;
              credit       <= '0;
              out          <= ST_NO_INGR;
            end else if (!funds_ok) begin
              out <= ST_NO_FUNDS;
            end else begin
              state  <= SERVE;
              credit <= credit - price_sel;
              serve  <= sel_oh;
              cnt    <= CNT_LOAD;
              out    <= ST_SERVING;
            end
          end
        end

        SERVE: begin
          // Counter reaching zero marks the last visible serve cycle; hand off without a gap.
          if (cnt == '0) begin
            serve <= '0;
            if (credit != '0) begin
              state        <= CHANGE;
              change_valid <= 1'b1;
              change       <= credit;
              credit       <= '0;
              out          <= ST_CHANGE;
            end else begin
              state <= IDLE;
              out   <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        CHANGE, REFUND: begin
          // Payout pulse is visible for exactly this one cycle.
          state        <= IDLE;
          change_valid <= 1'b0;
          change       <= '0;
          out          <= ST_IDLE;
        end

        default: begin
          state        <= IDLE;
          credit       <= '0;
          serve        <= '0;
          change_valid <= 1'b0;
          change       <= '0;
          out          <= ST_IDLE;
          cnt          <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maquina_bebidas_param.sv
// Purpose: directed self-checking bench for maquina_bebidas_param with default parameters.
// Latency: checks taken 1 ns after each rising edge, inputs driven at the same point.
// Backpressure: exercises coin reject, ignored strobes during serve and mid-serve reset.
module tb_maquina_bebidas_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       hm;
  logic [3:0] tm;
  logic       ha;
  logic [1:0] hc;
  logic       bp;
  logic [0:0] bb;
  logic       cancel;
  logic [4:0] credit;
  logic [1:0] serve;
  logic       change_valid;
  logic [4:0] change;
  logic [2:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  maquina_bebidas_param dut (
    .clk          (clk),
    .rst          (rst),
    .hm           (hm),
    .tm           (tm),
    .ha           (ha),
    .hc           (hc),
    .bp           (bp),
    .bb           (bb),
    .cancel       (cancel),
    .credit       (credit),
    .serve        (serve),
    .change_valid (change_valid),
    .change       (change),
    .out          (out)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int cr, input int sv, input int cv, input int ch, input int o);
    check({tag, ".credit"}, 32'(credit), 32'(cr));
    check({tag, ".serve"},  32'(serve),  32'(sv));
    check({tag, ".cv"},     32'(change_valid), 32'(cv));
    check({tag, ".change"}, 32'(change), 32'(ch));
    check({tag, ".out"},    32'(out),    32'(o));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int v);
    hm = 1'b1;
    tm = 4'(v);
    tick();
    hm = 1'b0;
    tm = '0;
  endtask

  task automatic press(input int sel);
    bp = 1'b1;
    bb = 1'(sel);
    tick();
    bp = 1'b0;
  endtask

  // Safety net in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; hm = 0; tm = '0; ha = 1; hc = 2'b11; bp = 0; bb = '0; cancel = 0;
    #12;
    chk_outs("reset", 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();

    // T1: exact price, no change.
    coin(5);
    chk_outs("t1.coin", 5, 0, 0, 0, 1);
    press(0);
    chk_outs("t1.serve1", 0, 1, 0, 0, 2);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("t1.serve_n", 32'(serve), 32'd1);
    end
    tick();
    chk_outs("t1.done", 0, 0, 0, 0, 0);

    // T2: back-to-back coins, change after serve.
    coin(5);
    coin(10);
    check("t2.credit15", 32'(credit), 32'd15);
    press(1);
    chk_outs("t2.serve1", 5, 2, 0, 0, 2);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("t2.serve_n", 32'(serve), 32'd2);
    end
    tick();
    chk_outs("t2.change", 0, 0, 1, 5, 3);
    tick();
    chk_outs("t2.idle", 0, 0, 0, 0, 0);

    // T3: insufficient credit, then cancel.
    coin(5);
    press(1);
    chk_outs("t3.nofunds", 5, 0, 0, 0, 7);
    tick();
    chk_outs("t3.revert", 5, 0, 0, 0, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk_outs("t3.cancel", 0, 0, 1, 5, 6);
    tick();
    chk_outs("t3.idle", 0, 0, 0, 0, 0);

    // T4: no water, then no ingredient.
    coin(10);
    ha = 1'b0;
    press(0);
    ha = 1'b1;
    chk_outs("t4.nowater", 0, 0, 1, 10, 4);
    tick();
    chk_outs("t4.idle", 0, 0, 0, 0, 0);
    hc = 2'b10;
    coin(10);
    press(0);
    hc = 2'b11;
    chk_outs("t4.noingr", 0, 0, 1, 10, 5);
    tick();

    // T5: overflow reject, max credit, priorities.
    coin(10); coin(10); coin(10);
    check("t5.credit30", 32'(credit), 32'd30);
    coin(5);
    chk_outs("t5.reject", 30, 0, 1, 5, 6);
    tick();
    chk_outs("t5.revert", 30, 0, 0, 0, 1);
    coin(1);
    chk_outs("t5.max31", 31, 0, 0, 0, 1);
    cancel = 1'b1;
    coin(5);
    cancel = 1'b0;
    chk_outs("t5.cancel_hm", 0, 0, 1, 31, 6);
    tick();
    hm = 1'b1; tm = 4'd5; bp = 1'b1; bb = 1'b0;
    tick();
    hm = 1'b0; tm = '0; bp = 1'b0;
    chk_outs("t5.hm_bp", 5, 0, 0, 0, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("t5.refund5", 32'(change), 32'd5);
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk_outs("t5.cancel0", 0, 0, 0, 0, 0);

    // T6: coins ignored during serve, reset in fourth serve cycle.
    coin(5);
    press(0);
    hm = 1'b1; tm = 4'd5;
    tick();
    tick();
    hm = 1'b0; tm = '0;
    chk_outs("t6.serve3", 0, 1, 0, 0, 2);
    tick();
    check("t6.serve4", 32'(serve), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk_outs("t6.rst", 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    tick();
    coin(5);
    check("t6.after_rst", 32'(credit), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
